data_mem_lsu: RTL and testbench
===============================

Name: data_mem_lsu

Overview:
- Parametrised successor to the single-port word data memory in the RISC-V pipelined core's MEM stage.
- Adds byte/halfword/word (and doubleword when DATA_W=64) loads and stores with RISC-V funct3 encoding, byte-lane write enables, and sign/zero extension.
- Adds misalignment detection, a pipeline hold input, and a post-reset zero-initialisation sweep with a ready handshake.
- Synchronous read with 1-cycle latency, same as the existing data memory.

Parameters:
- DATA_W, 32, memory word width in bits; legal values 32 or 64.
- DEPTH, 64, number of words; must be a power of two and at least 2.
- ADDR_W, 32, width of the byte address input.
- INIT_ZERO, 1, 1 = run the zeroing sweep after reset; 0 = skip it, ready asserts the cycle after reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  access request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 011 D (DATA_W=64 only), 100 BU, 101 HU, 110 WU (DATA_W=64 only)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- hold  in  1  pipeline stall; freezes the response register
- ready  out  1  block accepts requests
- rsp_valid  out  1  load response valid
- rsp_rdata  out  DATA_W  extended load data
- rsp_err  out  1  misaligned or illegal-size access flagged

Behaviour:
- Reset: synchronous, active-high on rst (one clock domain, clk).
  - All outputs reset to 0: ready, rsp_valid, rsp_rdata, rsp_err.
  - rst mid-sweep restarts the sweep from index 0.
- Index and offset: LB=log2(DATA_W/8) offset bits; word index = addr[LB+log2(DEPTH)-1:LB]. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- FSM:
  - INIT: counter runs 0..DEPTH-1, writing 0 to one word per cycle; ready=0. After the write to DEPTH-1, go to RUN.
  - RUN: ready=1.
  - With INIT_ZERO=0, the FSM goes directly to RUN.
  - Requests while ready=0 are ignored: no write, no response.
- Access accepted when req_valid & ready & !hold.
- Alignment: the address must be a multiple of the access size. Illegal sizes are 111, and 011/110 when DATA_W=32.
  - A misaligned or illegal access performs no write.
  - It produces rsp_valid=1 and rsp_err=1 next cycle, for loads and stores alike, with rsp_rdata=0.
- Store: byte enables cover size bytes starting at addr offset; req_wdata low bytes are shifted into those lanes. The write commits at the accepting edge; rsp_valid is not raised for a good store.
- Load: registered read at the accepting edge. The offset and funct3 are registered alongside the read data. Output logic shifts right by offset*8, masks to size, and sign- or zero-extends per funct3.
  - rsp_valid=1 and rsp_err=0 in the next cycle.
  - Load latency: exactly 1 cycle.
- Read-during-write: the array is single-ported and each request is either a load or a store, so a same-cycle conflict cannot occur. A load in the cycle after a store to the same word returns the new data.
- hold=1: no access is accepted. rsp_valid, rsp_rdata and rsp_err keep their values. The internal FSM and sweep continue.
- When no access is accepted and hold=0, rsp_valid and rsp_err go to 0 next cycle; rsp_rdata keeps its last value.

Decomposition:
- Shared package:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU.
  - FSM state encoding: ST_INIT, ST_RUN.
  - A function returning size-in-bytes from funct3.
- One natural sub-module, load_align_ext: purely combinational offset shift, mask and sign/zero extension, reusable by a future cache. The storage array, byte-enable write and FSM stay in data_mem_lsu.

Test Plan:
- Reset and sweep: rst high 1 cycle with INIT_ZERO=1, DEPTH=64 -> ready=0 for 64 cycles then 1. A request issued mid-sweep is ignored. LW at 0xFC returns 0.
- Byte/half stores:
  - SW 0x80 <- 0x11223344; then SB 0x81 <- 0xAA; then LW 0x80 -> 0x1122AA44.
  - SH 0x82 <- 0xBEEF; then LW 0x80 -> 0xBEEFAA44.
- Sign/zero extension: word 0x80 = 0x8000FF7F.
  - LB 0x81 -> 0xFFFFFFFF; LBU 0x81 -> 0x000000FF.
  - LH 0x82 -> 0xFFFF8000; LHU 0x82 -> 0x00008000.
- Misaligned:
  - LW 0x82 -> rsp_valid=1, rsp_err=1, rdata=0.
  - SH 0x83 <- 0x1234 -> rsp_err=1, memory unchanged (LW 0x80 unchanged).
- Hold and back-to-back:
  - LW A then LW B with hold=1 on the second cycle -> A data held on rsp_rdata; B is accepted only when hold drops and returns 1 cycle later.
  - SW X then immediate LW X -> new data.
- Wrap and width: DATA_W=64, DEPTH=16.
  - SD 0x80 aliases index 0; LD 0x0 returns the stored value.
  - LWU 0x4 zero-extends the upper word.

Source files
------------

// File: rtl/data_mem_lsu_pkg.sv
// Shared definitions for the data memory load/store unit: RISC-V funct3
// size codes, FSM state encoding and a size decoder.
package data_mem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } lsu_state_e;

    // Access size in bytes; the low two funct3 bits encode log2(size).
    function automatic logic [3:0] f3_size_bytes(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

endpackage

// File: rtl/data_mem_lsu_align.sv
// load_align_ext: combinational load data alignment. Shifts the raw memory
// word right by the byte offset, masks to the access size and sign- or
// zero-extends according to funct3 (bit 2 set = unsigned).
module load_align_ext
    import data_mem_lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [OFF_W-1:0]  offset_i,
    input  logic [2:0]        funct3_i,
    output logic [DATA_W-1:0] data_o
);

    localparam int SW = $clog2(DATA_W);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic [SW-1:0]     sign_idx;
    logic              sign_bit;
    int                nbits;

    // Shift, mask and extend the selected bytes.
    always_comb begin
        shifted  = data_i >> (int'(offset_i) * 8);
        nbits    = int'(f3_size_bytes(funct3_i)) * 8;
        mask     = '1;
        sign_idx = SW'(DATA_W - 1);
        if (nbits < DATA_W) begin
            mask     = ~({DATA_W{1'b1}} << nbits);
            sign_idx = SW'(nbits - 1);
        end
        sign_bit = shifted[sign_idx] & ~funct3_i[2];
        data_o   = (shifted & mask) | ({DATA_W{sign_bit}} & ~mask);
    end

endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: single-ported word data memory with RISC-V sized loads and
// stores, byte-lane writes, misalignment detection, a pipeline hold and a
// post-reset zeroing sweep gated by the ready output.
//
// Handshake: a request is accepted on a rising edge when
// req_valid & ready & !hold. Accepted loads and any faulting access return
// rsp_valid one cycle later; good stores return nothing. hold freezes the
// response outputs.
module data_mem_lsu
    import data_mem_lsu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 32,
    parameter int INIT_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              hold,
    output logic              ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    lsu_state_e        state_q;
    logic [IW-1:0]     sweep_cnt_q;

    logic [DATA_W-1:0] rd_data_q;
    logic [LB-1:0]     rd_off_q;
    logic [2:0]        rd_f3_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;

    logic [LB-1:0]     off;
    logic [IW-1:0]     idx;
    logic [3:0]        size;
    logic              illegal;
    logic              misaligned;
    logic              bad;
    logic              acc;
    logic              st_ok;
    logic              ld_ok;
    logic              sweep_we;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wdata_sh;
    logic              unused_addr;

    // Address split: byte offset within the word and word index; upper
    // address bits are dropped so accesses wrap modulo DEPTH words.
    assign off         = req_addr[LB-1:0];
    assign idx         = req_addr[LB+IW-1:LB];
    assign unused_addr = ^req_addr;

    assign size       = f3_size_bytes(req_funct3);
    assign illegal    = (req_funct3 == 3'b111) ||
                        ((DATA_W == 32) && ((req_funct3 == F3_D) || (req_funct3 == F3_WU)));
    assign misaligned = ((4'(off) & (size - 4'd1)) != 4'd0);
    assign bad        = illegal | misaligned;

    assign acc   = req_valid & ready & ~hold;
    assign st_ok = acc & req_we & ~bad;
    assign ld_ok = acc & ~req_we & ~bad;

    assign sweep_we = (state_q == ST_INIT) && (INIT_ZERO != 0);

    // Byte enables span size bytes starting at the address offset.
    always_comb begin
        be = '0;
        for (int b = 0; b < NB; b++) begin
            be[b] = (b >= int'(off)) && (b < int'(off) + int'(size));
        end
    end

    assign wdata_sh = req_wdata << (int'(off) * 8);

    // Init/run FSM: the sweep counter walks every word once, then ready rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            sweep_cnt_q <= '0;
            ready       <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if ((INIT_ZERO == 0) || (sweep_cnt_q == IW'(DEPTH - 1))) begin
                        state_q <= ST_RUN;
                        ready   <= 1'b1;
                    end else begin
                        sweep_cnt_q <= sweep_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state_q <= ST_INIT;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: zeroing sweep or byte-lane store (never both, since
    // ready is low during the sweep).
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem_q[sweep_cnt_q] <= '0;
        end else if (st_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem_q[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
                end
            end
        end
    end

    // Registered read with its offset and size code; a faulting access
    // clears the data so the extended response reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
            rd_off_q  <= '0;
            rd_f3_q   <= '0;
        end else if (acc && bad) begin
            rd_data_q <= '0;
            rd_off_q  <= '0;
            rd_f3_q   <= F3_W;
        end else if (ld_ok) begin
            rd_data_q <= mem_q[idx];
            rd_off_q  <= off;
            rd_f3_q   <= req_funct3;
        end
    end

    // Response flags: frozen under hold, otherwise reflect this cycle's access.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else if (!hold) begin
            rsp_valid_q <= acc & (bad | ~req_we);
            rsp_err_q   <= acc & bad;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

    load_align_ext #(
        .DATA_W (DATA_W),
        .OFF_W  (LB)
    ) u_align (
        .data_i   (rd_data_q),
        .offset_i (rd_off_q),
        .funct3_i (rd_f3_q),
        .data_o   (rsp_rdata)
    );

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: a 32-bit/64-word instance and a 64-bit/16-word
// instance, driven from a vector table plus hand-written sweep and hold
// sequences. Inputs change on the falling edge; outputs are sampled there too.
module tb_data_mem_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance signals
    logic        rst_a, v_a, we_a, hold_a;
    logic [2:0]  f3_a;
    logic [31:0] addr_a;
    logic [31:0] wd_a;
    logic        rdy_a, rv_a, err_a;
    logic [31:0] rd_a;

    // 64-bit instance signals
    logic        rst_b, v_b, we_b, hold_b;
    logic [2:0]  f3_b;
    logic [31:0] addr_b;
    logic [63:0] wd_b;
    logic        rdy_b, rv_b, err_b;
    logic [63:0] rd_b;

    int total = 0;
    int bad   = 0;

    data_mem_lsu #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .INIT_ZERO(1)) dut_a (
        .clk(clk), .rst(rst_a), .req_valid(v_a), .req_we(we_a), .req_funct3(f3_a),
        .req_addr(addr_a), .req_wdata(wd_a), .hold(hold_a), .ready(rdy_a),
        .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(err_a)
    );

    data_mem_lsu #(.DATA_W(64), .DEPTH(16), .ADDR_W(32), .INIT_ZERO(1)) dut_b (
        .clk(clk), .rst(rst_b), .req_valid(v_b), .req_we(we_b), .req_funct3(f3_b),
        .req_addr(addr_b), .req_wdata(wd_b), .hold(hold_b), .ready(rdy_b),
        .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(err_b)
    );

    typedef struct {
        string       name;
        logic        w64;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic        exp_v;
        logic        exp_e;
        logic [63:0] exp_d;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(input string name, input logic w64, input logic we,
                                input logic [2:0] f3, input logic [31:0] addr,
                                input logic [63:0] wdata, input logic ev,
                                input logic ee, input logic [63:0] ed);
        vec_t v;
        v.name = name; v.w64 = w64; v.we = we; v.f3 = f3; v.addr = addr;
        v.wdata = wdata; v.exp_v = ev; v.exp_e = ee; v.exp_d = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // Present one request for a single cycle and check the response.
    task automatic apply(input vec_t v);
        logic        gv, ge;
        logic [63:0] gd;
        if (v.w64) begin
            v_b = 1'b1; we_b = v.we; f3_b = v.f3; addr_b = v.addr; wd_b = v.wdata;
        end else begin
            v_a = 1'b1; we_a = v.we; f3_a = v.f3; addr_a = v.addr; wd_a = v.wdata[31:0];
        end
        @(negedge clk);
        v_a = 1'b0;
        v_b = 1'b0;
        if (v.w64) begin
            gv = rv_b; ge = err_b; gd = rd_b;
        end else begin
            gv = rv_a; ge = err_a; gd = {32'h0, rd_a};
        end
        chk({v.name, " valid"}, 64'(gv), 64'(v.exp_v));
        chk({v.name, " err"}, 64'(ge), 64'(v.exp_e));
        if (v.exp_v) chk({v.name, " rdata"}, gd, v.exp_d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; v_a = 1'b0; we_a = 1'b0; hold_a = 1'b0; f3_a = 3'b010; addr_a = '0; wd_a = '0;
        rst_b = 1'b1; v_b = 1'b0; we_b = 1'b0; hold_b = 1'b0; f3_b = 3'b011; addr_b = '0; wd_b = '0;

        // ---------- 32-bit instance: reset values and zeroing sweep ----------
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        chk("rst ready", 64'(rdy_a), 64'd0);
        chk("rst rsp_valid", 64'(rv_a), 64'd0);
        chk("rst rsp_err", 64'(err_a), 64'd0);
        chk("rst rsp_rdata", {32'h0, rd_a}, 64'd0);
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            chk($sformatf("sweep ready c%0d", i), 64'(rdy_a), 64'(i >= 64));
            if (i == 11 || i == 12) chk($sformatf("sweep ignored c%0d", i), 64'(rv_a), 64'd0);
            if (i == 10) begin
                v_a = 1'b1; we_a = 1'b1; f3_a = 3'b010; addr_a = 32'h0; wd_a = 32'hFFFF_FFFF;
            end else if (i == 11) begin
                we_a = 1'b0;
            end else if (i == 12) begin
                v_a = 1'b0;
            end
        end

        // ---------- vector table ----------
        tab.push_back(mk("LW 0xFC",        0, 0, 3'b010, 32'hFC,  64'h0,          1, 0, 64'h0));
        tab.push_back(mk("LW 0x0 swept",   0, 0, 3'b010, 32'h0,   64'h0,          1, 0, 64'h0));
        tab.push_back(mk("SW 0x80",        0, 1, 3'b010, 32'h80,  64'h11223344,   0, 0, 64'h0));
        tab.push_back(mk("SB 0x81",        0, 1, 3'b000, 32'h81,  64'hAA,         0, 0, 64'h0));
        tab.push_back(mk("LW after SB",    0, 0, 3'b010, 32'h80,  64'h0,          1, 0, 64'h1122AA44));
        tab.push_back(mk("SH 0x82",        0, 1, 3'b001, 32'h82,  64'hBEEF,       0, 0, 64'h0));
        tab.push_back(mk("LW after SH",    0, 0, 3'b010, 32'h80,  64'h0,          1, 0, 64'hBEEFAA44));
        tab.push_back(mk("SW ext word",    0, 1, 3'b010, 32'h80,  64'h8000FF7F,   0, 0, 64'h0));
        tab.push_back(mk("LB 0x81",        0, 0, 3'b000, 32'h81,  64'h0,          1, 0, 64'hFFFFFFFF));
        tab.push_back(mk("LBU 0x81",       0, 0, 3'b100, 32'h81,  64'h0,          1, 0, 64'h000000FF));
        tab.push_back(mk("LH 0x82",        0, 0, 3'b001, 32'h82,  64'h0,          1, 0, 64'hFFFF8000));
        tab.push_back(mk("LHU 0x82",       0, 0, 3'b101, 32'h82,  64'h0,          1, 0, 64'h00008000));
        tab.push_back(mk("LB 0x80",        0, 0, 3'b000, 32'h80,  64'h0,          1, 0, 64'h0000007F));
        tab.push_back(mk("LW 0x82 misal",  0, 0, 3'b010, 32'h82,  64'h0,          1, 1, 64'h0));
        tab.push_back(mk("SH 0x83 misal",  0, 1, 3'b001, 32'h83,  64'h1234,       1, 1, 64'h0));
        tab.push_back(mk("LW unchanged",   0, 0, 3'b010, 32'h80,  64'h0,          1, 0, 64'h8000FF7F));
        tab.push_back(mk("LD on 32 illeg", 0, 0, 3'b011, 32'h80,  64'h0,          1, 1, 64'h0));
        tab.push_back(mk("f3 111 illeg",   0, 1, 3'b111, 32'h80,  64'h5,          1, 1, 64'h0));
        tab.push_back(mk("SW 0x180 wrap",  0, 1, 3'b010, 32'h180, 64'hCAFEF00D,   0, 0, 64'h0));
        tab.push_back(mk("LW 0x80 wrap",   0, 0, 3'b010, 32'h80,  64'h0,          1, 0, 64'hCAFEF00D));
        tab.push_back(mk("LHU 0x82 wrap",  0, 0, 3'b101, 32'h82,  64'h0,          1, 0, 64'h0000CAFE));
        tab.push_back(mk("LH 0x80",        0, 0, 3'b001, 32'h80,  64'h0,          1, 0, 64'hFFFFF00D));
        tab.push_back(mk("LBU 0x83",       0, 0, 3'b100, 32'h83,  64'h0,          1, 0, 64'h000000CA));
        tab.push_back(mk("SW A 0x40",      0, 1, 3'b010, 32'h40,  64'h0A0A0A0A,   0, 0, 64'h0));
        tab.push_back(mk("SW B 0x44",      0, 1, 3'b010, 32'h44,  64'h0B0B0B0B,   0, 0, 64'h0));
        foreach (tab[k]) apply(tab[k]);
        tab.delete();

        // ---------- hold with back-to-back loads ----------
        v_a = 1'b1; we_a = 1'b0; f3_a = 3'b010; addr_a = 32'h40; hold_a = 1'b0;
        @(negedge clk);
        chk("hold A valid", 64'(rv_a), 64'd1);
        chk("hold A rdata", {32'h0, rd_a}, 64'h0A0A0A0A);
        addr_a = 32'h44; hold_a = 1'b1;
        @(negedge clk);
        chk("hold c1 valid", 64'(rv_a), 64'd1);
        chk("hold c1 rdata", {32'h0, rd_a}, 64'h0A0A0A0A);
        @(negedge clk);
        chk("hold c2 valid", 64'(rv_a), 64'd1);
        chk("hold c2 rdata", {32'h0, rd_a}, 64'h0A0A0A0A);
        hold_a = 1'b0;
        @(negedge clk);
        chk("hold B valid", 64'(rv_a), 64'd1);
        chk("hold B rdata", {32'h0, rd_a}, 64'h0B0B0B0B);
        v_a = 1'b0;
        @(negedge clk);
        chk("idle valid", 64'(rv_a), 64'd0);
        chk("idle rdata kept", {32'h0, rd_a}, 64'h0B0B0B0B);

        // ---------- 64-bit instance: sweep restart on mid-sweep reset ----------
        rst_b = 1'b0;
        repeat (5) @(negedge clk);
        chk("b mid-sweep ready", 64'(rdy_b), 64'd0);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk($sformatf("b sweep ready c%0d", i), 64'(rdy_b), 64'(i >= 16));
        end

        tab.push_back(mk("b LD 0x8 zero",  1, 0, 3'b011, 32'h8,  64'h0,                 1, 0, 64'h0));
        tab.push_back(mk("b SD 0x80",      1, 1, 3'b011, 32'h80, 64'hF1E2D3C4B5A69788,  0, 0, 64'h0));
        tab.push_back(mk("b LD 0x0 alias", 1, 0, 3'b011, 32'h0,  64'h0,                 1, 0, 64'hF1E2D3C4B5A69788));
        tab.push_back(mk("b LWU 0x4",      1, 0, 3'b110, 32'h4,  64'h0,                 1, 0, 64'h00000000F1E2D3C4));
        tab.push_back(mk("b LW 0x4",       1, 0, 3'b010, 32'h4,  64'h0,                 1, 0, 64'hFFFFFFFFF1E2D3C4));
        tab.push_back(mk("b LW 0x0",       1, 0, 3'b010, 32'h0,  64'h0,                 1, 0, 64'hFFFFFFFFB5A69788));
        tab.push_back(mk("b LB 0x7",       1, 0, 3'b000, 32'h7,  64'h0,                 1, 0, 64'hFFFFFFFFFFFFFFF1));
        tab.push_back(mk("b LWU 0x2 mis",  1, 0, 3'b110, 32'h2,  64'h0,                 1, 1, 64'h0));
        tab.push_back(mk("b f3 111",       1, 0, 3'b111, 32'h0,  64'h0,                 1, 1, 64'h0));
        tab.push_back(mk("b SW 0x8",       1, 1, 3'b010, 32'h8,  64'h12345678,          0, 0, 64'h0));
        tab.push_back(mk("b LD 0x8 low",   1, 0, 3'b011, 32'h8,  64'h0,                 1, 0, 64'h0000000012345678));
        tab.push_back(mk("b SW 0xC",       1, 1, 3'b010, 32'hC,  64'h9ABCDEF0,          0, 0, 64'h0));
        tab.push_back(mk("b LD 0x8 full",  1, 0, 3'b011, 32'h8,  64'h0,                 1, 0, 64'h9ABCDEF012345678));
        tab.push_back(mk("b SD 0x1C mis",  1, 1, 3'b011, 32'h1C, 64'h1,                 1, 1, 64'h0));
        foreach (tab[k]) apply(tab[k]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
